// File: rtl/fsqrt_iter_if.sv
// Request/response bundle for the iterative single-precision square-root unit.
//   req_valid/req_ready/x     : operand handshake (x sampled on acceptance)
//   resp_valid/resp_ready/y   : result handshake (y stable while resp_valid)
//   busy                      : unit is in any state other than idle
// master modport: requester side; slave modport: the sqrt unit.
interface fsqrt_iter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] x;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] y;
  logic        busy;

  modport master (
    output req_valid, x, resp_ready,
    input  req_ready, resp_valid, y, busy
  );

  modport slave (
    input  req_valid, x, resp_ready,
    output req_ready, resp_valid, y, busy
  );
endinterface

// File: rtl/fsqrt_iter.sv
// Iterative IEEE-754 single-precision square root (flush-to-zero on denormals).
// Restoring digit recurrence, round to nearest.
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : fsqrt_iter_if.slave (req_valid/req_ready/x, resp_valid/resp_ready/y, busy)
// Build option: define FSQRT_ITER_RADIX4_EN to retire two root bits per cycle
// (13 calc cycles instead of 25). Results are identical in both builds.
module fsqrt_iter (
  input  logic         clk,
  input  logic         rstn,
  fsqrt_iter_if.slave  bus
);

`ifdef FSQRT_ITER_RADIX4_EN
  localparam int unsigned RootW      = 26;
  localparam int unsigned BitsPerCyc = 2;
`else
  localparam int unsigned RootW      = 25;
  localparam int unsigned BitsPerCyc = 1;
`endif
  localparam int unsigned RadW    = 2 * RootW;
  localparam int unsigned RemW    = RootW + 3;
  localparam int unsigned CntW    = 5;
  localparam int unsigned LastCnt = RootW / BitsPerCyc - 1;

  typedef enum logic [1:0] {StIdle, StCalc, StPack, StDone} state_e;

  state_e            state_q, state_d;
  logic              live_q, live_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RadW-1:0]   rad_q, rad_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [RootW-1:0]  root_q, root_d;
  logic [7:0]        exp_q, exp_d;
  logic [31:0]       y_q, y_d;

  // Operand decode
  logic        x_sgn;
  logic [7:0]  x_exp;
  logic [22:0] x_man;
  logic        accept, special;
  logic [31:0] spec_y;
  logic [24:0] sig;
  logic [7:0]  exp_init;

  always_comb begin
    x_sgn    = bus.x[31];
    x_exp    = bus.x[30:23];
    x_man    = bus.x[22:0];
    accept   = live_q && (state_q == StIdle) && bus.req_valid;
    special  = 1'b1;
    spec_y   = 32'h7FC0_0000;
    if (x_exp == 8'hFF && x_man != 23'd0) begin
      spec_y = 32'h7FC0_0000;
    end else if (x_exp == 8'd0) begin
      spec_y = {x_sgn, 31'd0};  // zero and flushed denormal keep the sign
    end else if (x_sgn) begin
      spec_y = 32'h7FC0_0000;
    end else if (x_exp == 8'hFF) begin
      spec_y = 32'h7F80_0000;
    end else begin
      special = 1'b0;
    end
    // Odd biased exponent means even unbiased exponent: no pre-shift needed.
    sig      = x_exp[0] ? {2'b01, x_man} : {1'b1, x_man, 1'b0};
    exp_init = x_exp[0] ? 8'((9'(x_exp) + 9'd127) >> 1) : 8'((9'(x_exp) + 9'd126) >> 1);
  end

  // One calc cycle: BitsPerCyc restoring steps, each consuming two radicand bits.
  logic [RadW-1:0]  rad_t;
  logic [RemW-1:0]  rem_t, rem_sh, trial;
  logic [RootW-1:0] root_t;

  always_comb begin
    rad_t  = rad_q;
    rem_t  = rem_q;
    root_t = root_q;
    rem_sh = '0;
    trial  = '0;
    for (int i = 0; i < BitsPerCyc; i++) begin
      rem_sh = {rem_t[RemW-3:0], rad_t[RadW-1 -: 2]};
      trial  = RemW'({root_t, 2'b01});
      rad_t  = rad_t << 2;
      if (rem_sh >= trial) begin
        rem_t  = rem_sh - trial;
        root_t = {root_t[RootW-2:0], 1'b1};
      end else begin
        rem_t  = rem_sh;
        root_t = {root_t[RootW-2:0], 1'b0};
      end
    end
  end

  // Rounding: root top 24 bits are the mantissa, next bit rounds.
  logic        rnd_bit, sticky, inc;
  logic [24:0] mant_r;
  logic [31:0] pack_y;

  always_comb begin
    rnd_bit = root_q[RootW-25];
`ifdef FSQRT_ITER_RADIX4_EN
    sticky  = root_q[0] | (|rem_q);
`else
    sticky  = |rem_q;
`endif
    inc     = rnd_bit & (sticky | root_q[RootW-24]);
    mant_r  = {1'b0, root_q[RootW-1 -: 24]} + 25'(inc);
    // On carry-out the fraction field is all zeros and the exponent bumps.
    pack_y  = {1'b0, exp_q + {7'd0, mant_r[24]}, mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
  end

  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    exp_d   = exp_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (special) begin
            y_d     = spec_y;
            state_d = StDone;
          end else begin
            rad_d   = {sig, {(RadW - 25){1'b0}}};
            rem_d   = '0;
            root_d  = '0;
            exp_d   = exp_init;
            cnt_d   = CntW'(LastCnt);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rad_d  = rad_t;
        rem_d  = rem_t;
        root_d = root_t;
        if (cnt_q == '0) begin
          state_d = StPack;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPack: begin
        y_d     = pack_y;
        state_d = StDone;
      end
      StDone: begin
        if (bus.resp_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      live_q  <= 1'b0;  // keeps req_ready low while reset is held
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      exp_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      exp_q   <= exp_d;
      y_q     <= y_d;
    end
  end

  assign bus.req_ready  = live_q && (state_q == StIdle);
  assign bus.resp_valid = (state_q == StDone);
  assign bus.busy       = (state_q != StIdle);
  assign bus.y          = y_q;

endmodule

// File: tb/tb_fsqrt_iter.sv
// Self-checking bench for fsqrt_iter: directed vectors with hand-computed
// results, special operands, backpressure, mid-calc reset and a small sweep
// checked against a double-precision reference within 1 ulp.
module tb_fsqrt_iter;

`ifdef FSQRT_ITER_RADIX4_EN
  localparam int NormLat = 14;
`else
  localparam int NormLat = 26;
`endif

  logic clk;
  logic rstn;
  fsqrt_iter_if bus ();

  fsqrt_iter u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one operand (called ~1 time unit after a rising edge) and wait for
  // the response; lat counts rising edges after the accepting edge.
  task automatic do_op(input logic [31:0] xin, input logic rr,
                       output logic [31:0] yout, output int lat);
    bus.x          = xin;
    bus.req_valid  = 1'b1;
    bus.resp_ready = rr;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.x         = 32'hDEAD_BEEF;
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    yout = bus.y;
  endtask

  task automatic release_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  function automatic logic [31:0] ref_sqrt(input logic [31:0] xv);
    logic [63:0] db;
    logic [63:0] rb;
    logic [10:0] de;
    logic [31:0] s;
    real         r;
    de = 11'(xv[30:23]) + 11'd896;
    db = {1'b0, de, xv[22:0], 29'd0};
    r  = $sqrt($bitstoreal(db));
    rb = $realtobits(r);
    s  = {1'b0, 8'(rb[62:52] - 11'd896), rb[51:29]};
    s  = s + 32'(rb[28]);
    return s;
  endfunction

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] y;
    int          lat;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.x          = '0;
    rstn           = 1'b1;
    #1 rstn = 1'b0;
    #20;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_y", bus.y, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    vecs.push_back('{32'h4080_0000, 32'h4000_0000, NormLat});  // 4.0
    vecs.push_back('{32'h4000_0000, 32'h3FB5_04F3, NormLat});  // 2.0
    vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, NormLat});  // 1.0
    vecs.push_back('{32'h3E80_0000, 32'h3F00_0000, NormLat});  // 0.25
    vecs.push_back('{32'h4180_0000, 32'h4080_0000, NormLat});  // 16.0
    vecs.push_back('{32'hC080_0000, 32'h7FC0_0000, 0});        // -4.0
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 0});        // -0
    vecs.push_back('{32'h0000_0001, 32'h0000_0000, 0});        // denormal
    vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 0});        // +inf
    vecs.push_back('{32'hFF80_0000, 32'h7FC0_0000, 0});        // -inf
    vecs.push_back('{32'h7FA0_0001, 32'h7FC0_0000, 0});        // sNaN

    foreach (vecs[i]) begin
      // Alternate: consumer ready before resp_valid, or only afterwards.
      do_op(vecs[i].x, (i % 2 == 0), y, lat);
      check_eq($sformatf("y[%h]", vecs[i].x), y, vecs[i].y);
      check_eq($sformatf("lat[%h]", vecs[i].x), 32'(lat), 32'(vecs[i].lat));
      release_resp();
      check_eq($sformatf("idle[%h]", vecs[i].x), 32'(bus.req_ready), 32'd1);
    end

    // Backpressure on 9.0
    do_op(32'h4110_0000, 1'b0, y, lat);
    check_eq("bp_y", y, 32'h4040_0000);
    check_eq("bp_lat", 32'(lat), 32'(NormLat));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_y", bus.y, 32'h4040_0000);
      check_eq("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check_eq("bp_release_busy", 32'(bus.busy), 32'd0);
    check_eq("bp_release_ready", 32'(bus.req_ready), 32'd1);

    // Reset in the middle of the recurrence
    bus.x         = 32'h4080_0000;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("mid_busy_before", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("mid_rst_y", bus.y, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_post_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check_eq("mid_no_resp", 32'(bus.resp_valid), 32'd0);
    do_op(32'h4080_0000, 1'b1, y, lat);
    check_eq("mid_retry_y", y, 32'h4000_0000);
    check_eq("mid_retry_lat", 32'(lat), 32'(NormLat));
    release_resp();

    // Sweep E in {99,160} against the double-precision reference
    for (int i = 0; i < 24; i++) begin
      logic [31:0] xs;
      logic [31:0] r;
      logic [31:0] diff;
      logic [22:0] m;
      m  = (i == 0) ? 23'd0 : (i == 1) ? 23'h7F_FFFF : 23'($urandom);
      xs = {1'b0, (i % 2 == 1) ? 8'd160 : 8'd99, m};
      do_op(xs, 1'b1, y, lat);
      r    = ref_sqrt(xs);
      diff = (y > r) ? y - r : r - y;
      check_eq($sformatf("sweep[%h]", xs), (diff <= 32'd1) ? r : y, r);
      release_resp();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsqrt_iter.md
FSQRT_ITER -- requirements
Module: fsqrt_iter

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rstn  input  1  asynchronous reset, active-low.
REQ-003 req_valid  input  1  operand x valid.
REQ-004 req_ready  output  1  unit can accept an operand.
REQ-005 x  input  32  IEEE-754 single operand, sampled on acceptance.
REQ-006 resp_valid  output  1  result y valid.
REQ-007 resp_ready  input  1  consumer takes y.
REQ-008 y  output  32  IEEE-754 single sqrt(x), held stable while resp_valid=1.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 States IDLE, CALC, PACK, DONE; req_ready=1 only in IDLE.
REQ-011 Acceptance is a rising edge with state=IDLE and req_valid=1; x is latched into an internal register; later changes on x are ignored.
REQ-012 Normal operand (sign=0, E in 1..254): IDLE->CALC on acceptance.
REQ-013 Radicand is {1,m} for odd E and {1,m}<<1 for even E; result exponent is (E+127)>>1 for odd E and (E+126)>>1 for even E.
REQ-014 CALC runs a restoring radix-2 digit recurrence, one root bit per cycle, 25 cycles (24 root bits plus 1 round bit); a down-counter 24..0 ends CALC at 0 -> PACK.
REQ-015 PACK rounds to nearest: sticky = (partial remainder != 0); increment the mantissa if round bit=1; a mantissa carry-out increments the exponent; then -> DONE.
REQ-016 Normal-path latency: resp_valid is first high after the 26th rising edge following the accepting edge.
REQ-017 Special operands go IDLE->DONE on the accepting edge, so resp_valid is high in the next cycle.
REQ-018 Special results: +/-0 -> same-signed 0; denormal (E=0, m!=0) is flushed to a same-signed 0.
REQ-019 Special results: +inf -> 0x7F800000; any NaN -> 0x7FC00000; negative nonzero (including -inf) -> 0x7FC00000.
REQ-020 DONE: resp_valid=1 and y holds; on an edge with resp_ready=1 -> IDLE. resp_ready may already be high when resp_valid rises.
REQ-021 No new request is accepted in the same edge that completes a response; the next acceptance is possible one edge later.
REQ-022 resp_ready is ignored outside DONE; req_valid is ignored outside IDLE.
REQ-023 Normal-path results are within 1 ulp of the correctly rounded sqrt; the exact-square cases in the Verification section are bit-exact.

Reset
REQ-024 rstn=0 forces IDLE immediately, regardless of clk and of any operation in progress.
REQ-025 During rstn=0: req_ready=0, resp_valid=0, busy=0, y=0, counter=0, and the remainder and root registers are 0.
REQ-026 On the first edge after rstn rises, state is IDLE and req_ready=1.
REQ-027 A reset in CALC, PACK or DONE discards the operation; no response is produced for it.

Configuration
REQ-028 Macro FSQRT_ITER_RADIX4_EN.
REQ-029 Macro defined: CALC produces 2 root bits per cycle for 13 cycles (26 bits; the lowest is folded into sticky), and normal-path latency is 14 edges.
REQ-030 Macro undefined: radix-2 behaviour per REQ-014 and REQ-016. Results are identical in both builds.

Verification
REQ-031 x=0x40800000 (4.0), resp_ready=1 -> y=0x40000000, with resp_valid rising 26 edges after acceptance (14 with the macro).
REQ-032 x=0x40000000 (2.0) -> y=0x3FB504F3; x=0x3F800000 (1.0) -> y=0x3F800000.
REQ-033 x=0xC0800000 -> y=0x7FC00000; x=0x80000000 -> y=0x80000000; x=0x00000001 -> y=0x00000000; x=0x7F800000 -> y=0x7F800000. Each has resp_valid high in the cycle after acceptance.
REQ-034 Backpressure: x=0x41100000 (9.0) with resp_ready=0 for 10 cycles after resp_valid -> y=0x40400000 held stable and req_ready=0 throughout; resp_ready=1 -> IDLE the next edge.
REQ-035 Reset mid-CALC: assert rstn=0 at iteration 10 -> outputs take reset values immediately; a subsequent x=0x40800000 yields 0x40000000 with normal latency.
REQ-036 Random sweep: all mantissas, E in {99,160}, compared against a reference sqrt -> error within 1 ulp per REQ-023.
